turn_controller: RTL and testbench

- Sequencing controller for the chess clock.
- Turns raw game events (start, pause, player move-done buttons, per-player time-zero flags) into the SELECT / STOP / END controls of the player-enable switch.
- Emits one-cycle increment pulses to the per-player timers and counts full moves.
- Sits between the debounced button front-end and the switch/timer datapath.

---
 rtl/chess_clock_pkg.sv | 25 ++
 rtl/turn_controller_if.sv | 30 +++
 rtl/turn_controller_lockout_timer.sv | 30 +++
 rtl/turn_controller.sv | 180 ++++++++++++++++++
 tb/tb_turn_controller.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/chess_clock_pkg.sv
// Shared encodings for the chess clock sequencing blocks.
// State codes are visible on the STATE debug port, so their values are fixed.
package chess_clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN_P1 = 3'd1,
        ST_RUN_P2 = 3'd2,
        ST_PAUSED = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic SIDE_P1 = 1'b0;
    localparam logic SIDE_P2 = 1'b1;

    // Timers are halted in every state except the two running states.
    function automatic logic is_halted(state_t s);
        return (s == ST_IDLE) || (s == ST_PAUSED) || (s == ST_OVER);
    endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Event inputs and switch/timer controls of the turn controller.
// master = button front-end side, slave = turn_controller.
interface turn_controller_if #(
    parameter int MOVE_W = 10
);
    logic              START;
    logic              PAUSE;
    logic              BTN_P1;
    logic              BTN_P2;
    logic              ZERO_P1;
    logic              ZERO_P2;
    logic              SELECT;
    logic              STOP;
    logic              END;
    logic              INC_P1;
    logic              INC_P2;
    logic [MOVE_W-1:0] MOVE_CNT;
    logic [1:0]        WINNER;
    logic [2:0]        STATE;

    modport master (
        output START, PAUSE, BTN_P1, BTN_P2, ZERO_P1, ZERO_P2,
        input  SELECT, STOP, END, INC_P1, INC_P2, MOVE_CNT, WINNER, STATE
    );

    modport slave (
        input  START, PAUSE, BTN_P1, BTN_P2, ZERO_P1, ZERO_P2,
        output SELECT, STOP, END, INC_P1, INC_P2, MOVE_CNT, WINNER, STATE
    );
endinterface

// File: rtl/turn_controller_lockout_timer.sv
// Post-turn-change button lockout: loadable down-counter with zero flag.
// clear has priority over load; the count stops at zero.
module lockout_timer #(
    parameter int GUARD_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [GUARD_W-1:0] load_val,
    output logic               zero
);

    logic [GUARD_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/turn_controller.sv
// Chess clock turn sequencer: game events in, SELECT/STOP/END and
// increment pulses out, with a saturating full-move counter.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | no game, timers halted, waiting for START
// ST_RUN_P1 | player 1 clock running
// ST_RUN_P2 | player 2 clock running
// ST_PAUSED | both halted, resume returns to saved side
// ST_OVER   | a flag fell, END/WINNER held until START
module turn_controller
    import chess_clock_pkg::*;
#(
    parameter int MOVE_W       = 10,
    parameter int GUARD_CYCLES = 50,
    parameter int GUARD_W      = 6
) (
    input logic              CLK,
    input logic              CLR_N,
    turn_controller_if.slave bus
);

    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);

    state_t            state_q, state_d;
    logic              saved_q, saved_d;
    logic [1:0]        winner_q, winner_d;
    logic              select_q, select_d;
    logic              stop_q;
    logic              end_q;
    logic              inc1_q, inc1_d;
    logic              inc2_q, inc2_d;
    logic [MOVE_W-1:0] move_q;
    logic              move_inc;
    logic              move_clr;
    logic              lock_load;
    logic              lock_clear;
    logic              lock_zero;

    lockout_timer #(
        .GUARD_W (GUARD_W)
    ) u_lockout (
        .clk      (CLK),
        .rst_n    (CLR_N),
        .clear    (lock_clear),
        .load     (lock_load),
        .load_val (GUARD_LOAD),
        .zero     (lock_zero)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The active side's flag is checked first so a falling flag beats a
    // same-cycle move press, and the idle side's inputs never matter.
    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        winner_d   = winner_q;
        inc1_d     = 1'b0;
        inc2_d     = 1'b0;
        move_inc   = 1'b0;
        move_clr   = 1'b0;
        lock_load  = 1'b0;
        lock_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_RUN_P1;
                end
            end

            ST_RUN_P1: begin
                if (bus.ZERO_P1) begin
                    state_d  = ST_OVER;
                    winner_d = WIN_P2;
                end else if (bus.PAUSE) begin
                    state_d = ST_PAUSED;
                    saved_d = SIDE_P1;
                end else if (bus.BTN_P1 && lock_zero) begin
                    state_d   = ST_RUN_P2;
                    inc1_d    = 1'b1;
                    lock_load = 1'b1;
                end
            end

            ST_RUN_P2: begin
                if (bus.ZERO_P2) begin
                    state_d  = ST_OVER;
                    winner_d = WIN_P1;
                end else if (bus.PAUSE) begin
                    state_d = ST_PAUSED;
                    saved_d = SIDE_P2;
                end else if (bus.BTN_P2 && lock_zero) begin
                    state_d   = ST_RUN_P1;
                    inc2_d    = 1'b1;
                    lock_load = 1'b1;
                    move_inc  = 1'b1;
                end
            end

            ST_PAUSED: begin
                if (bus.PAUSE) begin
                    state_d = (saved_q == SIDE_P2) ? ST_RUN_P2 : ST_RUN_P1;
                end
            end

            ST_OVER: begin
                if (bus.START) begin
                    state_d    = ST_IDLE;
                    winner_d   = WIN_NONE;
                    move_clr   = 1'b1;
                    lock_clear = 1'b1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                lock_clear = 1'b1;
            end
        endcase
    end

    // SELECT follows the running side and freezes while paused or over.
    always_comb begin
        select_d = select_q;
        case (state_d)
            ST_IDLE:   select_d = SIDE_P1;
            ST_RUN_P1: select_d = SIDE_P1;
            ST_RUN_P2: select_d = SIDE_P2;
            default:   select_d = select_q;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            saved_q  <= SIDE_P1;
            winner_q <= WIN_NONE;
            select_q <= SIDE_P1;
            stop_q   <= 1'b1;
            end_q    <= 1'b0;
            inc1_q   <= 1'b0;
            inc2_q   <= 1'b0;
        end else begin
            saved_q  <= saved_d;
            winner_q <= winner_d;
            select_q <= select_d;
            stop_q   <= is_halted(state_d);
            end_q    <= (state_d == ST_OVER);
            inc1_q   <= inc1_d;
            inc2_q   <= inc2_d;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            move_q <= '0;
        end else if (move_clr) begin
            move_q <= '0;
        end else if (move_inc && (move_q != '1)) begin
            move_q <= move_q + 1'b1;
        end
    end

    assign bus.SELECT   = select_q;
    assign bus.STOP     = stop_q;
    assign bus.END      = end_q;
    assign bus.INC_P1   = inc1_q;
    assign bus.INC_P2   = inc2_q;
    assign bus.MOVE_CNT = move_q;
    assign bus.WINNER   = winner_q;
    assign bus.STATE    = state_q;

endmodule

// File: tb/tb_turn_controller.sv
// Randomized check of turn_controller (MOVE_W=10 and MOVE_W=2 builds driven
// in lockstep) against a game-level reference model.
module tb_turn_controller;

    localparam int GUARD = 50;

    logic clk_sys = 1'b0;
    logic rst_b   = 1'b0;

    always #5 clk_sys = ~clk_sys;

    turn_controller_if #(.MOVE_W(10)) bus_a ();
    turn_controller_if #(.MOVE_W(2))  bus_b ();

    turn_controller #(.MOVE_W(10)) dut_a (
        .CLK   (clk_sys),
        .CLR_N (rst_b),
        .bus   (bus_a)
    );

    turn_controller #(.MOVE_W(2)) dut_b (
        .CLK   (clk_sys),
        .CLR_N (rst_b),
        .bus   (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // game model: phase 0 no game, 1 playing, 2 paused, 3 finished
    int m_phase, m_side, m_lock, m_moves, m_winner, m_inc1, m_inc2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_state();
        case (m_phase)
            0:       return 0;
            1:       return 1 + m_side;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_side = 0; m_lock = 0; m_moves = 0;
        m_winner = 0; m_inc1 = 0; m_inc2 = 0;
    endtask

    task automatic model_step(input bit st, input bit pa, input bit b1, input bit b2,
                              input bit z1, input bit z2);
        int nlock;
        bit flag, btn;
        nlock  = (m_lock > 0) ? m_lock - 1 : 0;
        m_inc1 = 0;
        m_inc2 = 0;
        case (m_phase)
            0: if (st) begin m_phase = 1; m_side = 0; end
            1: begin
                flag = (m_side == 1) ? z2 : z1;
                btn  = (m_side == 1) ? b2 : b1;
                if (flag) begin
                    m_phase  = 3;
                    m_winner = (m_side == 1) ? 1 : 2;
                end else if (pa) begin
                    m_phase = 2;
                end else if (btn && m_lock == 0) begin
                    if (m_side == 0) m_inc1 = 1;
                    else begin m_inc2 = 1; m_moves++; end
                    m_side = 1 - m_side;
                    nlock  = GUARD;
                end
            end
            2: if (pa) m_phase = 1;
            default: if (st) begin
                m_phase = 0; m_moves = 0; m_winner = 0; m_side = 0; nlock = 0;
            end
        endcase
        m_lock = nlock;
    endtask

    task automatic check_all();
        int sat_a, sat_b;
        sat_a = (m_moves > 1023) ? 1023 : m_moves;
        sat_b = (m_moves > 3) ? 3 : m_moves;
        chk("a_state",  bus_a.STATE,    exp_state());
        chk("a_select", bus_a.SELECT,   m_side);
        chk("a_stop",   bus_a.STOP,     (m_phase != 1));
        chk("a_end",    bus_a.END,      (m_phase == 3));
        chk("a_inc1",   bus_a.INC_P1,   m_inc1);
        chk("a_inc2",   bus_a.INC_P2,   m_inc2);
        chk("a_winner", bus_a.WINNER,   m_winner);
        chk("a_moves",  bus_a.MOVE_CNT, sat_a);
        chk("b_state",  bus_b.STATE,    exp_state());
        chk("b_select", bus_b.SELECT,   m_side);
        chk("b_stop",   bus_b.STOP,     (m_phase != 1));
        chk("b_inc",    {bus_b.INC_P1, bus_b.INC_P2}, {m_inc1[0], m_inc2[0]});
        chk("b_winner", bus_b.WINNER,   m_winner);
        chk("b_moves",  bus_b.MOVE_CNT, sat_b);
    endtask

    task automatic drive(input bit st, input bit pa, input bit b1, input bit b2,
                         input bit z1, input bit z2);
        bus_a.START = st; bus_a.PAUSE = pa; bus_a.BTN_P1 = b1; bus_a.BTN_P2 = b2;
        bus_a.ZERO_P1 = z1; bus_a.ZERO_P2 = z2;
        bus_b.START = st; bus_b.PAUSE = pa; bus_b.BTN_P1 = b1; bus_b.BTN_P2 = b2;
        bus_b.ZERO_P1 = z1; bus_b.ZERO_P2 = z2;
    endtask

    task automatic cycle(input bit st, input bit pa, input bit b1, input bit b2,
                         input bit z1, input bit z2);
        drive(st, pa, b1, b2, z1, z2);
        model_step(st, pa, b1, b2, z1, z2);
        @(negedge clk_sys);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all();
        chk("rst_stop", bus_a.STOP, 1'b1);
        @(negedge clk_sys);
        rst_b = 1'b1;

        cycle(1, 0, 0, 0, 0, 0);
        chk("start_state", bus_a.STATE, 3'd1);
        chk("start_stop",  bus_a.STOP,  1'b0);
        cycle(0, 0, 1, 0, 0, 0);
        chk("inc1_pulse", bus_a.INC_P1, 1'b1);
        chk("sel_p2",     bus_a.SELECT, 1'b1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("inc1_once",  bus_a.INC_P1, 1'b0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("lock_drop",  bus_a.SELECT, 1'b1);
        idle(50);
        cycle(0, 0, 0, 1, 0, 0);
        chk("inc2_pulse", bus_a.INC_P2,   1'b1);
        chk("move1",      bus_a.MOVE_CNT, 10'd1);

        idle(52);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        chk("pause_stop", bus_a.STOP,   1'b1);
        chk("pause_sel",  bus_a.SELECT, 1'b1);
        cycle(0, 0, 0, 1, 0, 0);
        chk("pause_btn",  bus_a.STATE,  3'd3);
        cycle(0, 1, 0, 0, 0, 0);
        chk("resume",     bus_a.STATE,  3'd2);

        idle(52);
        cycle(0, 0, 0, 1, 0, 0);
        idle(52);
        cycle(0, 0, 1, 0, 1, 0);
        chk("zero_state",  bus_a.STATE,  3'd4);
        chk("zero_winner", bus_a.WINNER, 2'b10);
        chk("zero_noinc",  bus_a.INC_P1, 1'b0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("over_clr",    bus_a.WINNER, 2'b00);

        cycle(1, 0, 0, 0, 0, 0);
        for (int m = 0; m < 5; m++) begin
            idle(52);
            cycle(0, 0, 1, 0, 0, 0);
            idle(52);
            cycle(0, 0, 0, 1, 0, 0);
        end
        chk("sat_b", bus_b.MOVE_CNT, 2'd3);
        chk("sat_a", bus_a.MOVE_CNT, 10'd5);

        for (int i = 0; i < 6000; i++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 7) == 0,  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0);
        end

        rst_b = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk_sys);
        rst_b = 1'b1;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        chk("pre_rst_state", bus_a.STATE, 3'd2);
        #3;
        rst_b = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_rst_state", bus_a.STATE, 3'd0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
